// File: rtl/syn_fifo_ex.sv
// ----------------------------------------------------------------------------
// syn_fifo_ex -- parametrised single-clock FIFO
//
// Rate-decoupling buffer between a producer and a consumer in one clock
// domain. Generalises width and depth. Also provides:
//   - an occupancy count
//   - almost-full / almost-empty thresholds
//   - a read-valid strobe
//   - one-cycle overflow / underflow error pulses
//
// Build option:
//   SYN_FIFO_FWFT_EN   defined   : first-word-fall-through read port. rdata
//                                  shows the head word combinationally,
//                                  rvalid = ~empty, and re pops (acks) the
//                                  displayed word.
//                      undefined : standard registered read with 1-cycle
//                                  latency (the default).
//
// Handshake: a write is accepted when we=1 and the FIFO is not full. A read
// is accepted when re=1 and the FIFO is not empty. There is no bypass: a
// full FIFO rejects a write even if a read is accepted in the same cycle,
// and an empty FIFO rejects a read even if a write is accepted in the same
// cycle. A rejected request raises overflow/underflow for one cycle and
// changes no state.
//
// Ports:
//   clk           in   1       clock, rising edge
//   rst           in   1       synchronous active-high reset
//   we / wdata    in   1/W     write request and data
//   re            in   1       read request (pop in FWFT mode)
//   rdata         out  W       read data
//   rvalid        out  1       rdata carries a freshly popped word (std) /
//                              head word is valid (FWFT)
//   full, empty   out  1       count == DEPTH / count == 0
//   almost_full   out  1       count >= AFULL_TH
//   almost_empty  out  1       count <= AEMPTY_TH
//   count         out  AW+1    occupancy 0..DEPTH
//   overflow      out  1       registered pulse: write rejected
//   underflow     out  1       registered pulse: read rejected
// ----------------------------------------------------------------------------
module syn_fifo_ex #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C   = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C  = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc, rd_acc;

    // Flags come straight from the registered count, so they move on the
    // same edge that commits the operation.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept decisions use pre-edge state only (no bypass).
    assign wr_acc = we & ~full;
    assign rd_acc = re & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = we & full;
        underflow_d = re & empty;
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset; reset only blocks a same-cycle write so that
    // reset takes precedence over we.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    // Head word is always presented; re acknowledges it.
    assign rdata  = mem[rd_ptr_q];
    assign rvalid = ~empty;
`else
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            // rdata holds its last value on cycles without a pop.
            if (rd_acc) begin
                rdata_q <= mem[rd_ptr_q];
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_syn_fifo_ex.sv
// ----------------------------------------------------------------------------
// tb_syn_fifo_ex -- directed bench for syn_fifo_ex (WIDTH=32, DEPTH=4,
// AFULL_TH=3, AEMPTY_TH=1). The driver pushes the expected read word when it
// issues a read that must be accepted. The monitor pops and compares whenever
// the DUT presents a word. Flags, count and error pulses are checked by the
// driver 1 time unit after each edge.
// ----------------------------------------------------------------------------
module tb_syn_fifo_ex;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we  = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          re  = 1'b0;
    logic [W-1:0]  rdata;
    logic          rvalid;
    logic          full, empty, almost_full, almost_empty;
    logic [2:0]    count;
    logic          overflow, underflow;

    logic [W-1:0]  exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    syn_fifo_ex #(
        .WIDTH(32), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .wdata(wdata), .re(re),
        .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Standard mode: a popped word is presented while rvalid=1.
    // FWFT mode: a word is consumed in a cycle with rvalid & re.
    always @(negedge clk) begin
        logic present;
`ifdef SYN_FIFO_FWFT_EN
        present = rvalid & re;
`else
        present = rvalid;
`endif
        if (!rst && present) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_read: got %0h expected no word at %0t", rdata, $time);
            end else begin
                chk("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic w, input logic [W-1:0] d, input logic r);
        we    = w;
        wdata = d;
        re    = r;
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic wr(input logic [W-1:0] d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic rd(input logic [W-1:0] exp);
        exp_q.push_back(exp);
        step(1'b0, '0, 1'b1);
    endtask

    // Simultaneous write and accepted read.
    task automatic wr_rd(input logic [W-1:0] d, input logic [W-1:0] exp);
        exp_q.push_back(exp);
        step(1'b1, d, 1'b1);
    endtask

    task automatic chk_flags(input string tag, input int cnt, input logic f, input logic e,
                             input logic af, input logic ae);
        chk({tag, "_count"}, W'(count), W'(cnt));
        chk({tag, "_full"}, W'(full), W'(f));
        chk({tag, "_empty"}, W'(empty), W'(e));
        chk({tag, "_afull"}, W'(almost_full), W'(af));
        chk({tag, "_aempty"}, W'(almost_empty), W'(ae));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // 1. reset for two edges
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
        chk_flags("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("reset_rvalid", W'(rvalid), '0);
        chk("reset_ovf", W'(overflow), '0);
        chk("reset_unf", W'(underflow), '0);
`ifndef SYN_FIFO_FWFT_EN
        chk("reset_rdata", rdata, '0);
`endif

        // 2. fill and overflow
        wr(32'h11); chk_flags("w1", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        wr(32'h22); chk_flags("w2", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        wr(32'h33); chk_flags("w3", 3, 1'b0, 1'b0, 1'b1, 1'b0);
        wr(32'h44); chk_flags("w4", 4, 1'b1, 1'b0, 1'b1, 1'b0);
        wr(32'h55);
        chk("ovf_pulse", W'(overflow), 32'd1);
        chk("ovf_count", W'(count), 32'd4);
        step(1'b0, '0, 1'b0);
        chk("ovf_clear", W'(overflow), '0);

        // 3. drain and underflow
        rd(32'h11); chk("r1_count", W'(count), 32'd3);
        rd(32'h22); chk("r2_count", W'(count), 32'd2);
        rd(32'h33); chk("r3_count", W'(count), 32'd1);
        rd(32'h44); chk_flags("r4", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("unf_pulse", W'(underflow), 32'd1);
        chk("unf_rvalid", W'(rvalid), '0);
`ifndef SYN_FIFO_FWFT_EN
        chk("unf_rdata_hold", rdata, 32'h44);
`endif
        step(1'b0, '0, 1'b0);
        chk("unf_clear", W'(underflow), '0);

        // 4. wrap: count held at 2 while streaming 1..10
        wr(32'hA0);
        wr(32'hB0);
        wr_rd(32'd1, 32'hA0);
        chk("wrap_count", W'(count), 32'd2);
        wr_rd(32'd2, 32'hB0);
        chk("wrap_count", W'(count), 32'd2);
        for (int i = 3; i <= 10; i++) begin
            wr_rd(W'(i), W'(i - 2));
            chk("wrap_count", W'(count), 32'd2);
        end
        rd(32'd9);
        rd(32'd10);
        chk("wrap_empty", W'(empty), 32'd1);

        // 5a. full + we&re: read taken, write dropped
        wr(32'hC1); wr(32'hC2); wr(32'hC3); wr(32'hC4);
        wr_rd(32'hEE, 32'hC1);
        chk("fullrw_ovf", W'(overflow), 32'd1);
        chk("fullrw_count", W'(count), 32'd3);
        rd(32'hC2);
        rd(32'hC3);
        rd(32'hC4);
        chk("fullrw_empty", W'(empty), 32'd1);

        // 5b. empty + we&re: write taken, read rejected
        step(1'b1, 32'h77, 1'b1);
        chk("emptyrw_unf", W'(underflow), 32'd1);
        chk("emptyrw_ovf", W'(overflow), '0);
        chk("emptyrw_count", W'(count), 32'd1);
`ifndef SYN_FIFO_FWFT_EN
        chk("emptyrw_rvalid", W'(rvalid), '0);
`endif
        rd(32'h77);

        // 6. mid-operation reset at count 3, with a concurrent write
        wr(32'hD1); wr(32'hD2); wr(32'hD3);
        chk("pre_rst_count", W'(count), 32'd3);
        rst = 1'b1;
        step(1'b1, 32'hDD, 1'b0);
        rst = 1'b0;
        chk_flags("midrst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("midrst_unf", W'(underflow), 32'd1);

        // Fresh word after reset; in FWFT it must appear without a read.
        wr(32'hA5);
`ifdef SYN_FIFO_FWFT_EN
        chk("fwft_rdata", rdata, 32'hA5);
        chk("fwft_rvalid", W'(rvalid), 32'd1);
`endif
        rd(32'hA5);
        chk("final_empty", W'(empty), 32'd1);

        // Let the monitor see the last presented word.
        @(negedge clk);
        #1;
        chk("scoreboard_drained", W'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
